// File: rtl/ru_pkg.sv
// Shared constants and types for the register-unit write-port controller.
package ru_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef enum logic {CLEAR, RUN} ru_ctrl_st_t;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ru_wreq_t;

endpackage

// File: rtl/ru_wr_ctrl.sv
// Register-unit write-port sequencer: zeroes the file after reset, then arbitrates
// between core writeback (priority) and an aux requester with a starvation guard.
module ru_wr_ctrl #(
  parameter int XLEN         = ru_pkg::XLEN,
  parameter int NREG         = ru_pkg::NREG,
  parameter int STARVE_LIMIT = 4,
  parameter bit CLEAR_EN     = 1'b1,
  localparam int AW          = $clog2(NREG),
  localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            aux_valid,
  input  logic [AW-1:0]   aux_rd,
  input  logic [XLEN-1:0] aux_data,
  output logic            aux_ready,
  output logic            core_stall,
  output logic            clear_done,
  output logic            ru_wr,
  output logic [AW-1:0]   ru_rd,
  output logic [XLEN-1:0] ru_data
);
  import ru_pkg::*;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wreq_t;

  ru_ctrl_st_t   fsm;
  logic [AW-1:0] clr_idx;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_next;
  logic          force_aux;
  logic          core_blocks;
  wreq_t         win;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm        <= CLEAR_EN ? CLEAR : RUN;
      clr_idx    <= AW'(1);
      starve_cnt <= '0;
    end else begin
      case (fsm)
        CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(NREG - 1))
            fsm <= RUN;
        end
        default: starve_cnt <= starve_next;
      endcase
    end
  end

  always_comb begin
    win         = '0;
    aux_ready   = 1'b0;
    core_stall  = 1'b1;
    clear_done  = 1'b0;
    starve_next = starve_cnt;
    force_aux   = aux_valid && (starve_cnt == SW'(STARVE_LIMIT));
    // A core write to x0 is a no-op and must not block the aux side.
    core_blocks = wb_we && (wb_rd != '0);

    if (rst) begin
      if (fsm == CLEAR) begin
        win.we = 1'b1;
        win.rd = clr_idx;
      end else begin
        clear_done = 1'b1;
        core_stall = 1'b0;
        if (force_aux) begin
          core_stall  = 1'b1;
          aux_ready   = 1'b1;
          win         = '{we: 1'b1, rd: aux_rd, data: aux_data};
          starve_next = '0;
        end else if (core_blocks) begin
          win = '{we: 1'b1, rd: wb_rd, data: wb_data};
          // Blocked cycles only accumulate while aux keeps its request up.
          if (aux_valid)
            starve_next = (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + SW'(1);
          else
            starve_next = '0;
        end else begin
          aux_ready   = aux_valid;
          starve_next = '0;
          if (aux_valid)
            win = '{we: 1'b1, rd: aux_rd, data: aux_data};
        end
      end
    end

    // An accepted aux request to x0 is handshaken but never reaches the file.
    ru_wr   = win.we && (win.rd != '0);
    ru_rd   = win.rd;
    ru_data = win.data;
  end

endmodule

// File: tb/tb_ru_wr_ctrl.sv
// Bench for ru_wr_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_ru_wr_ctrl;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int SL   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            rst2 = 1'b0;
  logic            wb_we = 1'b0;
  logic [AW-1:0]   wb_rd = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            aux_valid = 1'b0;
  logic [AW-1:0]   aux_rd = '0;
  logic [XLEN-1:0] aux_data = '0;

  logic            aux_ready, core_stall, clear_done, ru_wr;
  logic [AW-1:0]   ru_rd;
  logic [XLEN-1:0] ru_data;
  logic            aux_ready2, core_stall2, clear_done2, ru_wr2;
  logic [AW-1:0]   ru_rd2;
  logic [XLEN-1:0] ru_data2;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: whether the zeroing walk is active, the next register it writes,
  // how many consecutive cycles a held aux request has been refused.
  bit m_clear = 1'b1;
  int m_next  = 1;
  int m_wait  = 0;
  bit m_acc   = 1'b0;

  always #5 clk = ~clk;

  ru_wr_ctrl #(.XLEN(XLEN), .NREG(NREG), .STARVE_LIMIT(SL), .CLEAR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_rd(aux_rd), .aux_data(aux_data),
    .aux_ready(aux_ready), .core_stall(core_stall), .clear_done(clear_done),
    .ru_wr(ru_wr), .ru_rd(ru_rd), .ru_data(ru_data)
  );

  ru_wr_ctrl #(.XLEN(XLEN), .NREG(NREG), .STARVE_LIMIT(SL), .CLEAR_EN(1'b0)) dut_nc (
    .clk(clk), .rst(rst2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_rd(aux_rd), .aux_data(aux_data),
    .aux_ready(aux_ready2), .core_stall(core_stall2), .clear_done(clear_done2),
    .ru_wr(ru_wr2), .ru_rd(ru_rd2), .ru_data(ru_data2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict outputs from current inputs, compare mid-cycle, advance model.
  task automatic step();
    logic            e_wr, e_ready, e_stall, e_done;
    logic [AW-1:0]   e_rd;
    logic [XLEN-1:0] e_data;
    bit n_clear;
    int n_next, n_wait;
    bit aux_win, core_win, core_req;
    #3;
    e_wr = 1'b0; e_rd = '0; e_data = '0; e_ready = 1'b0; e_stall = 1'b1; e_done = 1'b0;
    n_clear = m_clear; n_next = m_next; n_wait = m_wait;
    aux_win = 1'b0; core_win = 1'b0;
    if (!rst) begin
      n_clear = 1'b1; n_next = 1; n_wait = 0;
    end else if (m_clear) begin
      e_wr = 1'b1; e_rd = AW'(m_next);
      n_next = m_next + 1;
      if (m_next == NREG - 1) n_clear = 1'b0;
    end else begin
      e_done = 1'b1; e_stall = 1'b0;
      core_req = wb_we && (wb_rd != 0);
      if (aux_valid && m_wait == SL) begin
        aux_win = 1'b1; e_stall = 1'b1; n_wait = 0;
      end else if (core_req) begin
        core_win = 1'b1; n_wait = aux_valid ? m_wait + 1 : 0;
      end else begin
        aux_win = aux_valid; n_wait = 0;
      end
      if (aux_win) begin
        e_ready = 1'b1; e_rd = aux_rd; e_data = aux_data; e_wr = (aux_rd != 0);
      end
      if (core_win) begin
        e_rd = wb_rd; e_data = wb_data; e_wr = 1'b1;
      end
    end
    check("ru_wr",      32'(ru_wr),      32'(e_wr));
    check("ru_rd",      32'(ru_rd),      32'(e_rd));
    check("ru_data",    ru_data,         e_data);
    check("aux_ready",  32'(aux_ready),  32'(e_ready));
    check("core_stall", 32'(core_stall), 32'(e_stall));
    check("clear_done", 32'(clear_done), 32'(e_done));
    @(posedge clk);
    m_clear = n_clear; m_next = n_next; m_wait = n_wait; m_acc = aux_win;
    #1;
  endtask

  initial begin
    @(posedge clk); #1;

    // Reset held three cycles, then the full zeroing walk and one idle RUN cycle.
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (31) step();
    step();

    // Plain core writeback.
    wb_we = 1'b1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    step();
    wb_we = 1'b0;
    step();

    // Continuous core writes starve aux until the guard forces it through.
    wb_we = 1'b1; wb_rd = 3; wb_data = $urandom;
    aux_valid = 1'b1; aux_rd = 7; aux_data = 32'h1234;
    repeat (7) begin
      step();
      if (m_acc) aux_valid = 1'b0;
    end

    // Core write to x0 does not block aux; aux write to x0 is accepted but dropped.
    wb_rd = 0; aux_valid = 1'b1; aux_rd = 9; aux_data = $urandom;
    step();
    aux_rd = 0; aux_data = $urandom;
    step();
    aux_valid = 1'b0; wb_we = 1'b0;
    step();

    // Reset in the middle of the walk restarts it; a pending aux waits until RUN.
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (16) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    aux_valid = 1'b1; aux_rd = 4; aux_data = $urandom;
    repeat (31) step();
    step();
    aux_valid = 1'b0;
    step();

    // Random traffic, including rare resets and aux withdrawals.
    repeat (400) begin
      rst = ($urandom_range(0, 99) != 0);
      wb_we = ($urandom_range(0, 3) != 0);
      wb_rd = ($urandom_range(0, 5) == 0) ? AW'(0) : AW'($urandom);
      wb_data = $urandom;
      if (aux_valid && m_acc) aux_valid = 1'b0;
      else if (aux_valid && $urandom_range(0, 49) == 0) aux_valid = 1'b0;
      else if (!aux_valid && $urandom_range(0, 2) == 0) begin
        aux_valid = 1'b1;
        aux_rd = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
        aux_data = $urandom;
      end
      step();
    end

    // Instance without the zeroing walk: RUN immediately after reset release.
    wb_we = 1'b0; aux_valid = 1'b0;
    #3;
    check("nc_reset_done",  32'(clear_done2), 32'd0);
    check("nc_reset_stall", 32'(core_stall2), 32'd1);
    check("nc_reset_wr",    32'(ru_wr2),      32'd0);
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(posedge clk); #1;
    wb_we = 1'b1; wb_rd = 6; wb_data = 32'hCAFE0006;
    #3;
    check("nc_done",  32'(clear_done2), 32'd1);
    check("nc_stall", 32'(core_stall2), 32'd0);
    check("nc_wr",    32'(ru_wr2),      32'd1);
    check("nc_rd",    32'(ru_rd2),      32'd6);
    check("nc_data",  ru_data2,         32'hCAFE0006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
